stim_step_player: RTL and testbench
===================================

// Module: stim_step_player
// PURPOSE
//  Upstream stimulus stage for the 4-input sequence-checker FSM. Plays a programmed table of
//  (4-bit vector, hold duration) steps onto i1..i4, one step after another, so the checker
//  downstream sees a timed pattern sequence. Host loads the table, pulses start, waits for done.
// PARAMETERS
//  NUM_STEPS  16  table depth (steps)
//  ADDR_W     4   step index width, >= clog2(NUM_STEPS)
//  DUR_W      16  hold-duration width, in clk cycles
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  wr_en        in   1       table write strobe
//  wr_addr      in   ADDR_W  table write index
//  wr_vec       in   4       vector for step: {i4,i3,i2,i1}
//  wr_dur       in   DUR_W   hold cycles for step (0 treated as 1)
//  seq_len      in   ADDR_W+1 number of steps to play, sampled on accepted start
//  start        in   1       begin playback (pulse)
//  abort        in   1       stop playback immediately
//  loop_en      in   1       1: wrap to step 0 after last step
//  i1,i2,i3,i4  out  1 each  driven stimulus (registered)
//  step_idx     out  ADDR_W  index of step currently applied
//  step_strobe  out  1       1-cycle pulse on the cycle a new step's vector first appears
//  busy         out  1       playback active
//  done         out  1       1-cycle pulse when non-looping playback completes
// BEHAVIOUR
//  - Reset (async): state IDLE; i1..i4, step_idx, step_strobe, busy, done = 0; table cleared to 0.
//  - FSM: IDLE -> PLAY on start; PLAY -> PLAY on step advance; PLAY -> IDLE after last step
//    (loop_en=0) or on abort. No other states.
//  - Accepted start (IDLE only): latch len = min(seq_len, NUM_STEPS). Next edge: busy=1,
//    step_idx=0, {i4..i1}=table[0].vec, step_strobe=1, hold counter loaded with table[0].dur.
//  - Step holds exactly max(dur,1) cycles; on its last cycle the next edge applies step+1 vector
//    with step_strobe=1. Outputs never glitch between steps (no idle cycle between steps).
//  - Last step (index len-1) ends: loop_en=1 -> step 0 applied next edge, no done, busy stays 1;
//    loop_en=0 -> next edge i1..i4=0, busy=0, done=1 for one cycle, state IDLE. loop_en is
//    sampled at the end of each pass.
//  - seq_len=0 on start: no PLAY; next edge done=1 for one cycle, outputs stay 0, busy stays 0.
//  - seq_len > NUM_STEPS: clamped to NUM_STEPS.
//  - abort: highest priority, any state; next edge i1..i4=0, busy=0, step_strobe=0, no done pulse.
//    abort with start same cycle: abort wins, start dropped.
//  - start while busy: ignored. start in the done-pulse cycle is accepted (state already IDLE).
//  - Writes: accepted only in IDLE with start=0; wr_addr >= NUM_STEPS ignored; writes while
//    busy or coincident with start are dropped. Table write visible to next start.
//  - Counters: hold counter DUR_W bits, counts down, no wrap; step_idx wraps only via loop_en.
// TESTING
//  1 Load steps {vec,dur}: 0:{4'b0100,2},1:{4'b1101,3},2:{4'b0000,1}; seq_len=3, start ->
//    vectors 0100x2, 1101x3, 0000x1 cycles, 3 step_strobe pulses, done 1 cycle after, busy 0.
//  2 Same table, loop_en=1 -> after step 2 vector 0100 reappears with step_idx=0, no done; drop
//    loop_en mid pass -> done after that pass's step 2.
//  3 abort during step 1 hold -> next cycle i1..i4=0, busy=0, done never pulses; new start
//    replays from step 0.
//  4 dur=0 on step 0, seq_len=0, seq_len=20 -> step 0 holds 1 cycle; immediate done with busy 0;
//    20 clamped to 16 steps.
//  5 wr_en while busy, wr_en with start, wr_addr=16 -> all dropped; table unchanged on replay.
//  6 Assert reset mid step 1 (between clk edges) -> outputs 0 immediately, table reads back 0.

Source files
------------

// File: rtl/stim_step_player.sv
// Step-table stimulus player: replays programmed (vector, hold) steps onto i1..i4
// for the downstream sequence checker, with optional looping and abort.
module stim_step_player #(
  parameter int NUM_STEPS = 16,
  parameter int ADDR_W    = 4,
  parameter int DUR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_vec,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [ADDR_W:0]   seq_len,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  output logic              i1,
  output logic              i2,
  output logic              i3,
  output logic              i4,
  output logic [ADDR_W-1:0] step_idx,
  output logic              step_strobe,
  output logic              busy,
  output logic              done
);
  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_STEPS);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                            state_q, state_d;
  logic [NUM_STEPS-1:0][3:0]         tvec_q, tvec_d;
  logic [NUM_STEPS-1:0][DUR_W-1:0]   tdur_q, tdur_d;
  logic [ADDR_W:0]                   len_q, len_d;
  logic [ADDR_W-1:0]                 idx_q, idx_d;
  logic [DUR_W-1:0]                  cnt_q, cnt_d;
  logic [3:0]                        vec_q, vec_d;
  logic                              strobe_q, strobe_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;

  logic                              tbl_we;
  logic [ADDR_W:0]                   eff_len;
  logic [ADDR_W:0]                   last_idx;
  logic [ADDR_W-1:0]                 nxt_idx;

  // A zero hold is played as a single cycle.
  function automatic logic [DUR_W-1:0] hold_of(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  always_comb begin
    state_d  = state_q;
    tvec_d   = tvec_q;
    tdur_d   = tdur_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eff_len  = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
    last_idx = len_q - 1'b1;
    nxt_idx  = idx_q + 1'b1;

    tbl_we = (state_q == IDLE) && !start && wr_en && ({1'b0, wr_addr} < MAX_LEN);
    if (tbl_we) begin
      tvec_d[wr_addr[IDX_W-1:0]] = wr_vec;
      tdur_d[wr_addr[IDX_W-1:0]] = wr_dur;
    end

    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_d = eff_len;
            if (eff_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = PLAY;
              busy_d   = 1'b1;
              idx_d    = '0;
              vec_d    = tvec_q[0];
              cnt_d    = hold_of(tdur_q[0]);
              strobe_d = 1'b1;
            end
          end
        end
        PLAY: begin
          if (cnt_q > DUR_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else if ({1'b0, idx_q} != last_idx) begin
            idx_d    = nxt_idx;
            vec_d    = tvec_q[nxt_idx[IDX_W-1:0]];
            cnt_d    = hold_of(tdur_q[nxt_idx[IDX_W-1:0]]);
            strobe_d = 1'b1;
          end else if (loop_en) begin
            idx_d    = '0;
            vec_d    = tvec_q[0];
            cnt_d    = hold_of(tdur_q[0]);
            strobe_d = 1'b1;
          end else begin
            // Pass finished without looping: drop outputs and pulse done.
            state_d = IDLE;
            idx_d   = '0;
            vec_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tvec_q   <= '0;
      tdur_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      vec_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tvec_q   <= tvec_d;
      tdur_q   <= tdur_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign {i4, i3, i2, i1} = vec_q;
  assign step_idx         = idx_q;
  assign step_strobe      = strobe_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_stim_step_player.sv
// Bench for stim_step_player: a cycle-expanded timeline model plus directed literal checks.
module tb_stim_step_player;
  localparam int NS = 16;
  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_vec = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW:0]   seq_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          loop_en = 1'b0;
  logic          i1, i2, i3, i4;
  logic [AW-1:0] step_idx;
  logic          step_strobe, busy, done;

  int vectors = 0;
  int miscompares = 0;

  stim_step_player #(.NUM_STEPS(NS), .ADDR_W(AW), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_vec(wr_vec),
    .wr_dur(wr_dur), .seq_len(seq_len), .start(start), .abort(abort), .loop_en(loop_en),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .step_idx(step_idx), .step_strobe(step_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Each entry is what the outputs must show for one clock cycle.
  typedef struct packed {
    logic [3:0]    vec;
    logic [AW-1:0] idx;
    logic          strobe;
    logic          busy;
    logic          done;
  } ent_t;

  logic [3:0]    mvec [NS];
  logic [DW-1:0] mdur [NS];
  ent_t          q [$];
  ent_t          cur;
  int            mlen;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Unroll one pass of the table into per-cycle expected output entries.
  task automatic expand_pass();
    ent_t e;
    int d;
    for (int s = 0; s < mlen; s++) begin
      d = (mdur[s] == 0) ? 1 : int'(mdur[s]);
      for (int c = 0; c < d; c++) begin
        e.vec = mvec[s]; e.idx = AW'(s); e.strobe = (c == 0); e.busy = 1'b1; e.done = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    bit wr_ok;
    cur = '0;
    for (int i = 0; i < NS; i++) begin mvec[i] = '0; mdur[i] = '0; end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < NS; i++) begin mvec[i] = '0; mdur[i] = '0; end
        q.delete();
        cur = '0;
      end else begin
        wr_ok = !cur.busy && !start && wr_en && (int'(wr_addr) < NS);
        if (abort) begin
          q.delete();
          cur = '0;
        end else if (!cur.busy) begin
          cur = '0;
          if (start) begin
            mlen = (int'(seq_len) > NS) ? NS : int'(seq_len);
            if (mlen == 0) cur.done = 1'b1;
            else begin expand_pass(); cur = q.pop_front(); end
          end
        end else if (q.size() == 0) begin
          if (loop_en) begin expand_pass(); cur = q.pop_front(); end
          else begin cur = '0; cur.done = 1'b1; end
        end else begin
          cur = q.pop_front();
        end
        if (wr_ok) begin mvec[wr_addr[3:0]] = wr_vec; mdur[wr_addr[3:0]] = wr_dur; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("outputs_vs_model", 32'({i4, i3, i2, i1, step_idx, step_strobe, busy, done}),
            32'({cur.vec, cur.idx, cur.strobe, cur.busy, cur.done}));
    end
  end

  task automatic wr(input int a, input logic [3:0] v, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_vec = v; wr_dur = DW'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go(input int len);
    seq_len = (AW+1)'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int ns);
    bit seen;
    seen = 0; ns = 0;
    for (int i = 0; i < max && !seen; i++) begin
      if (step_strobe) ns++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  logic [3:0] ev [6] = '{4'b0100, 4'b0100, 4'b1101, 4'b1101, 4'b1101, 4'b0000};
  logic       es [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int ns;
    int r;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({i4, i3, i2, i1, step_idx, step_strobe, busy, done}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic three-step playback.
    wr(0, 4'b0100, 2); wr(1, 4'b1101, 3); wr(2, 4'b0000, 1);
    go(3);
    for (int k = 0; k < 6; k++) begin
      check("t1_vec", 32'({i4, i3, i2, i1}), 32'(ev[k]));
      check("t1_strobe_busy", 32'({step_strobe, busy}), 32'({es[k], 1'b1}));
      @(negedge clk);
    end
    check("t1_done", 32'({done, busy, i4, i3, i2, i1}), 32'b100000);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Looping, then drop loop_en mid pass.
    loop_en = 1'b1;
    go(3);
    repeat (6) @(negedge clk);
    check("t2_wrap", 32'({i4, i3, i2, i1, step_idx, step_strobe, busy, done}),
          32'({4'b0100, 5'd0, 1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    loop_en = 1'b0;
    wait_done(20, ns);
    @(negedge clk);

    // Abort during step 1.
    go(3);
    @(negedge clk); @(negedge clk);
    check("t3_in_step1", 32'(step_idx), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t3_abort", 32'({busy, step_strobe, i4, i3, i2, i1}), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("t3_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    go(3);
    check("t3_replay", 32'({i4, i3, i2, i1, step_idx}), 32'({4'b0100, 5'd0}));
    wait_done(20, ns);
    @(negedge clk);

    // Zero hold, zero length, clamped length.
    wr(0, 4'b0100, 0);
    go(1);
    check("t4_dur0", 32'({step_strobe, busy}), 32'b11);
    @(negedge clk);
    check("t4_dur0_end", 32'({done, busy}), 32'b10);
    @(negedge clk);
    go(0);
    check("t4_len0", 32'({done, busy, i4, i3, i2, i1}), 32'b100000);
    @(negedge clk);
    go(20);
    wait_done(100, ns);
    check("t4_clamp16", 32'(ns), 32'd16);
    @(negedge clk);

    // Dropped writes.
    go(3);
    wr(0, 4'b1111, 7);
    wait_done(20, ns);
    @(negedge clk);
    seq_len = 3; start = 1'b1; wr_en = 1'b1; wr_addr = 1; wr_vec = 4'b1111; wr_dur = 5;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done(20, ns);
    @(negedge clk);
    wr(16, 4'b1111, 5);
    go(3);
    check("t5_step0_kept", 32'({i4, i3, i2, i1}), 32'b0100);
    @(negedge clk);
    check("t5_step1_kept", 32'({i4, i3, i2, i1, step_idx}), 32'({4'b1101, 5'd1}));
    wait_done(20, ns);
    @(negedge clk);

    // Asynchronous reset mid playback clears outputs and the table.
    go(3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("t6_async_reset", 32'({i4, i3, i2, i1, step_idx, step_strobe, busy, done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    go(3);
    check("t6_table_cleared", 32'({i4, i3, i2, i1, busy}), 32'b00001);
    wait_done(10, ns);
    check("t6_steps", 32'(ns), 32'd3);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      abort   = (r < 2);
      start   = (r >= 2 && r < 8);
      seq_len = (AW+1)'($urandom_range(0, 20));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 19));
      wr_vec  = 4'($urandom_range(0, 15));
      wr_dur  = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 3) loop_en = !loop_en;
      @(negedge clk);
    end
    abort = 1'b1; start = 1'b0; wr_en = 1'b0; loop_en = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
